// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the seven-segment display blocks.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // BCD digit to pattern; non-decimal codes show a dash.
  function automatic logic [6:0] digit_pattern(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decode.sv
// Combinational BCD-to-segment decoder with a blank override.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the code so leading zeros can be suppressed.
  always_comb begin
    seg = blank ? SEG_BLANK : digit_pattern(code);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed common-anode driver with per-slot blanking gap
// and once-per-frame input snapshot.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIV = 25000,
  parameter int GAP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_mask,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  // Last counter value of the visible part of a slot.
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - GAP - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      idx_reg, idx_next;
  logic            snap_load;
  logic            frame_wrap;

  logic [3:0]      digit_in [4];
  logic [3:0]      digit_snap_reg [4];
  logic [3:0]      dp_mask_snap_reg;
  logic            blank_lead_snap_reg;

  logic [3:0]      cur_code;
  logic            blank3, blank2, cur_blank;
  logic [6:0]      dec_seg;

  assign digit_in[0] = d0;
  assign digit_in[1] = d1;
  assign digit_in[2] = d2;
  assign digit_in[3] = d3;

  // Next-state logic: slot counter, digit index and snapshot/frame events.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    snap_load  = 1'b0;
    frame_wrap = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      idx_next   = 2'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_SHOW;
          cnt_next   = '0;
          idx_next   = 2'd0;
          snap_load  = 1'b1;
        end
        default: begin
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
            idx_next   = idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              snap_load  = 1'b1;
              frame_wrap = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
            // With GAP=0 SHOW_LAST equals CNT_LAST, so this never fires.
            if (cnt_reg == SHOW_LAST) begin
              state_next = ST_GAP;
            end
          end
        end
      endcase
    end
  end

  // State, counter and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Snapshot of digits and controls, taken at frame start only.
  always_ff @(posedge clk) begin
    if (!reset && snap_load) begin
      for (int i = 0; i < 4; i++) begin
        digit_snap_reg[i] <= digit_in[i];
      end
      dp_mask_snap_reg    <= dp_mask;
      blank_lead_snap_reg <= blank_lead;
    end
  end

  // Leading-zero blanking cascades from the leftmost digit.
  always_comb begin
    cur_code  = digit_snap_reg[idx_reg];
    blank3    = blank_lead_snap_reg && (digit_snap_reg[3] == 4'd0);
    blank2    = blank3 && (digit_snap_reg[2] == 4'd0);
    cur_blank = ((idx_reg == 2'd3) && blank3) || ((idx_reg == 2'd2) && blank2);
  end

  seg_decode u_decode (
    .code  (cur_code),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  // Output registers: one cycle behind the state; dark at once on disable.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      an         <= 4'hF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (state_reg == ST_SHOW) begin
        an  <= cur_blank ? 4'hF : ~(4'b0001 << idx_reg);
        seg <= dec_seg;
        dp  <= ~dp_mask_snap_reg[idx_reg];
      end else begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomised and directed bench for sevenseg_scan against a time-based model.
module tb_sevenseg_scan;

  localparam int DIV = 8;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic [3:0] dp_mask = 4'd0;
  logic       blank_lead = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  sevenseg_scan #(.DIV(DIV), .GAP(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .dp_mask    (dp_mask),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    fd_cnt = 0;
  string phase = "init";

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model: elapsed cycles since the frame started plus the captured inputs.
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [3:0] m_snap [4];
  logic [3:0] m_dpm;
  logic       m_bl;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s.%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_take();
    m_snap[0] = d0; m_snap[1] = d1; m_snap[2] = d2; m_snap[3] = d3;
    m_dpm = dp_mask;
    m_bl  = blank_lead;
  endtask

  // Expected outputs after this edge, from the inputs sampled at it.
  task automatic model_step();
    int  slot, pos;
    bit  blanked;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (reset) begin
      m_active = 1'b0;
    end else if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t = 0;
      model_take();
    end else begin
      slot = (m_t / DIV) % 4;
      pos  = m_t % DIV;
      blanked = 1'b0;
      if (slot == 3) blanked = m_bl && (m_snap[3] == 4'd0);
      if (slot == 2) blanked = m_bl && (m_snap[3] == 4'd0) && (m_snap[2] == 4'd0);
      if (pos < DIV - GAP) begin
        e_dp = !m_dpm[slot];
        if (!blanked) begin
          e_an[slot] = 1'b0;
          e_seg = seg_tab[m_snap[slot]];
        end
      end
      e_fd = (slot == 3) && (pos == DIV - 1);
      m_t++;
      if (m_t % (4 * DIV) == 0) model_take();
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    fd_cnt += int'(frame_done);
    $display("[%s] t=%0t en=%0b an=%h seg=%h dp=%0b fd=%0b", phase, $time, en, an, seg, dp, frame_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    phase = "reset";
    reset = 1'b1; en = 1'b0;
    run(1);
    en = 1'b1;
    run(2);
    reset = 1'b0; en = 1'b0;
    run(4);

    phase = "scan";
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    en = 1'b1;
    fd_cnt = 0;
    run(66);
    chk("frame_done_count", 32'(fd_cnt), 32'd2);

    phase = "tear";
    run(20);
    d0 = 4'd9;
    run(48);

    phase = "blank";
    blank_lead = 1'b1; d3 = 4'd0; d2 = 4'd0;
    run(40);
    d2 = 4'd5;
    run(40);

    phase = "dash";
    blank_lead = 1'b0; d1 = 4'hC; dp_mask = 4'b0010;
    run(40);

    phase = "drop";
    en = 1'b0;
    run(2);
    en = 1'b1; d0 = 4'd7;
    run(12);
    en = 1'b0;
    run(2);
    en = 1'b1; d0 = 4'd2;
    run(20);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 63) != 0);
      d3         = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d2         = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d1         = 4'($urandom_range(0, 15));
      d0         = 4'($urandom_range(0, 15));
      dp_mask    = 4'($urandom_range(0, 15));
      blank_lead = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
